univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 26 ++
 rtl/usr_next_state.sv | 30 +++
 rtl/univ_shift_reg.sv | 66 ++++++
 3 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register.
// Holds the mode encoding used by the RTL and the bench.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        USR_HOLD = 3'b000,
        USR_LOAD = 3'b001,
        USR_SHL  = 3'b010,
        USR_SHR  = 3'b011,
        USR_ROL  = 3'b100,
        USR_ROR  = 3'b101,
        USR_CLR  = 3'b110,
        USR_INV  = 3'b111
    } usr_mode_e;

    // Modes that advance the shift counter.
    function automatic logic usr_is_shift(usr_mode_e m);
        return (m == USR_SHL) || (m == USR_SHR);
    endfunction

    // Modes that restart the shift counter.
    function automatic logic usr_is_restart(usr_mode_e m);
        return (m == USR_LOAD) || (m == USR_CLR);
    endfunction

endpackage

// File: rtl/usr_next_state.sv
// Next-value selector for the universal shift register.
// Ports: q/d/sin_l/sin_r/mode in, nq (next register value) out.
module usr_next_state
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  usr_mode_e        mode,
    output logic [WIDTH-1:0] nq
);

    always_comb begin
        nq = q;
        unique case (mode)
            USR_HOLD: nq = q;
            USR_LOAD: nq = d;
            USR_SHL:  nq = {q[WIDTH-2:0], sin_r};
            USR_SHR:  nq = {sin_l, q[WIDTH-1:1]};
            USR_ROL:  nq = {q[WIDTH-2:0], q[WIDTH-1]};
            USR_ROR:  nq = {q[0], q[WIDTH-1:1]};
            USR_CLR:  nq = '0;
            USR_INV:  nq = ~q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with saturating shift counter.
// Ports: clk, rst_n, en, mode, d, sin_r, sin_l in;
//        q, qb, sout_l, sout_r, shift_cnt, drained out.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  usr_mode_e        mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             drained
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] nq;
    logic [CW-1:0]    ncnt;

    usr_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .q     (q),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .mode  (mode),
        .nq    (nq)
    );

    // Counter saturates at WIDTH so drained stays asserted.
    always_comb begin
        ncnt = shift_cnt;
        if (usr_is_restart(mode)) begin
            ncnt = '0;
        end else if (usr_is_shift(mode) && shift_cnt != CNT_MAX) begin
            ncnt = shift_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            shift_cnt <= '0;
        end else if (en) begin
            q         <= nq;
            shift_cnt <= ncnt;
        end
    end

    assign qb      = ~q;
    assign sout_l  = q[WIDTH-1];
    assign sout_r  = q[0];
    assign drained = (shift_cnt == CNT_MAX);

endmodule
